// File: rtl/bram_pkg.sv
// Shared types and constants for the simple-dual-port block RAM.
package bram_pkg;

  typedef enum logic {RDW_READ_FIRST, RDW_WRITE_FIRST} rdw_mode_e;

  typedef enum logic {ST_CLEAR, ST_RUN} bram_state_e;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/bram_sdp_if.sv
// Write/read request bus of bram_sdp; the master issues requests, the RAM (slave) answers.
interface bram_sdp_if
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
);

  localparam int BE_W = DATA_WIDTH / BYTE_W;

  logic                  wr_en;
  logic [BE_W-1:0]       wr_be;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  ready;

  modport master (
    output wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, ready
  );

  modport slave (
    input  wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, ready
  );

endinterface

// File: rtl/bram_byte_merge.sv
// Combinational byte merge: enabled bytes come from new_i, the rest from old_i.
module bram_byte_merge
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]        old_i,
  input  logic [DATA_WIDTH-1:0]        new_i,
  input  logic [DATA_WIDTH/BYTE_W-1:0] be_i,
  output logic [DATA_WIDTH-1:0]        merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < DATA_WIDTH / BYTE_W; b++) begin
      if (be_i[b]) merged_o[b*BYTE_W +: BYTE_W] = new_i[b*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port block RAM: byte-enable write port, 1- or 2-cycle read port, selectable RDW policy.
// Define BRAM_INIT_CLEAR_EN to zero the whole array after reset before ready rises.
module bram_sdp
  import bram_pkg::*;
#(
  parameter int        DATA_WIDTH   = 32,
  parameter int        DEPTH        = 128,
  parameter int        ADDR_WIDTH   = $clog2(DEPTH),
  parameter int        READ_LATENCY = 1,
  parameter rdw_mode_e RDW_MODE     = RDW_READ_FIRST
) (
  input  logic      clk,
  input  logic      rst,
  bram_sdp_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  bram_state_e           state_q;
  logic                  ready_q;
  logic                  run_ok;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word_d;
  logic                  mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_waddr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic [DATA_WIDTH-1:0] s1_dat_q;
  logic                  s1_vld_q;

  assign run_ok      = ready_q && (state_q == ST_RUN);
  assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_L;
  assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_L;
  assign wr_acc      = run_ok && bus.wr_en && wr_in_range;
  assign rd_acc      = run_ok && bus.rd_en;
  assign wr_old      = mem[bus.wr_addr];

  bram_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_i   (wr_old),
    .new_i   (bus.wr_data),
    .be_i    (bus.wr_be),
    .merged_o(wr_merged)
  );

`ifdef BRAM_INIT_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] clr_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      ready_q    <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_addr_q == LAST_ADDR) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      ready_q <= 1'b0;
    end else begin
      state_q <= ST_RUN;
      ready_q <= 1'b1;
    end
  end
`endif

  // One physical write port, shared by the clear engine and user writes.
  always_comb begin
    mem_we_d    = wr_acc;
    mem_waddr_d = bus.wr_addr;
    mem_wdata_d = wr_merged;
`ifdef BRAM_INIT_CLEAR_EN
    if (state_q == ST_CLEAR && !rst) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = clr_addr_q;
      mem_wdata_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) mem[mem_waddr_d] <= mem_wdata_d;
  end

  always_comb begin
    rd_word_d = '0;
    if (rd_in_range) begin
      rd_word_d = mem[bus.rd_addr];
      if (RDW_MODE == RDW_WRITE_FIRST && wr_acc && bus.wr_addr == bus.rd_addr)
        rd_word_d = wr_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      s1_vld_q <= rd_acc;
      if (rd_acc) s1_dat_q <= rd_word_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_dat_q;
    logic                  s2_vld_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_vld_q <= 1'b0;
        s2_dat_q <= '0;
      end else begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) s2_dat_q <= s1_dat_q;
      end
    end

    assign bus.rd_data  = s2_dat_q;
    assign bus.rd_valid = s2_vld_q;
  end else begin : g_lat1
    assign bus.rd_data  = s1_dat_q;
    assign bus.rd_valid = s1_vld_q;
  end

  assign bus.ready = ready_q;

endmodule

// File: doc/bram_sdp.md
# bram_sdp

Parametrised simple-dual-port block RAM: one write port with byte enables and one independent read port, both on a single clock. It succeeds the single-port `bram` as the storage primitive behind the matrix buffers. It adds configurable read latency, a selectable read-during-write policy, and a `rd_valid` qualifier, so the matrix engine can write one matrix row while streaming another out. An optional post-reset clear engine zeroes the array before the block reports `ready`.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `DEPTH`, 128: number of words; any value ≥ 2, not necessarily a power of two.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: address width; derived, never overridden.
- `READ_LATENCY`, 1: cycles from read request to data; legal values are 1 and 2.
- `RDW_MODE`, `RDW_READ_FIRST`: same-address read/write collision policy, of type `rdw_mode_e`.
- `clk`, in, 1: single clock; everything is rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `wr_en`, in, 1: write request.
- `wr_be`, in, `DATA_WIDTH/8`: byte enables; bit i covers `wr_data[8i+7:8i]`.
- `wr_addr`, in, `ADDR_WIDTH`: write address.
- `wr_data`, in, `DATA_WIDTH`: write data.
- `rd_en`, in, 1: read request.
- `rd_addr`, in, `ADDR_WIDTH`: read address.
- `rd_data`, out, `DATA_WIDTH`: read data; holds its last value between reads.
- `rd_valid`, out, 1: one-cycle pulse marking new `rd_data`.
- `ready`, out, 1: the block accepts requests.

## Operation
- Reset values: `rd_data` = 0, `rd_valid` = 0, `ready` = 0. All read-pipeline stages are cleared.
- `rst` does not touch the array contents directly.
- The control FSM has two states, CLEAR and RUN. Reset enters CLEAR (or RUN when the clear feature is compiled out; see Configuration).
- CLEAR behaviour:
  - A counter writes 0 to addresses 0 to DEPTH-1, one per cycle, starting on the first edge after `rst` falls.
  - After the write to DEPTH-1, the FSM moves to RUN, and `ready` rises on that same edge.
- Requests are accepted only when `ready` = 1. A `wr_en` or `rd_en` presented while `ready` = 0 is discarded silently: no array change, no `rd_valid`.
- Write: on an edge with `wr_en` = 1, each byte whose `wr_be` bit is set is replaced. A `wr_be` of all zeros is a no-op.
- Read: on an edge with `rd_en` = 1, the word at `rd_addr` enters the read pipeline.
- Collision (`wr_en` and `rd_en` on the same address in the same cycle):
  - `RDW_READ_FIRST`: the read returns the pre-write word.
  - `RDW_WRITE_FIRST`: the read returns the merged word, i.e. enabled bytes from `wr_data` and the remaining bytes from the old word.
- Writes and reads to different addresses in the same cycle are fully independent.
- Out-of-range addresses (≥ DEPTH, possible when DEPTH is not a power of two):
  - A write is dropped.
  - A read still produces `rd_valid`, with `rd_data` = 0.
- Reset mid-operation: the asynchronous assertion clears the outputs and pipeline at once. Any in-flight read is lost, and its `rd_valid` never appears. A clear sequence interrupted by reset restarts from address 0.

## Timing
- Read latency: a request sampled at edge N gives `rd_data` and `rd_valid` = 1 after edge N+`READ_LATENCY`.
- With back-to-back requests, one result per cycle, in request order.
- With `READ_LATENCY` = 2, the second stage is a plain output register fed by the first stage.
- Write latency: a write at edge N is visible to a read sampled at edge N+1 under either `RDW_MODE`.
- Clear duration: exactly DEPTH cycles from the first edge after reset release to `ready` = 1.
- `ready` stays 1 until the next `rst`.

## Configuration
- `BRAM_INIT_CLEAR_EN` defined: the CLEAR state and the address counter are compiled in, and behaviour is exactly as described above.
- `BRAM_INIT_CLEAR_EN` undefined:
  - No counter is built, and the FSM resets straight into RUN.
  - `ready` rises on the first edge after `rst` falls.
  - Array contents after power-up are undefined (`X` in simulation).

## Structure
- Package `bram_pkg` holds:
  - `typedef enum logic {RDW_READ_FIRST, RDW_WRITE_FIRST} rdw_mode_e;`
  - the state enum `bram_state_e {ST_CLEAR, ST_RUN}`;
  - localparam `BYTE_W` = 8.
- Sub-module `bram_byte_merge` is combinational. It takes (old word, new word, byte enables) and returns the merged word. It is shared by the write path and the write-first bypass.
- The array is a single inferred `logic [DATA_WIDTH-1:0] mem [DEPTH]` so synthesis maps it to block RAM.

## Test plan
- Clear: set `DEPTH` = 16 and release `rst` → `ready` rises exactly 16 cycles later. Then read all 16 addresses → every word is 0 and each gives one `rd_valid` pulse.
- Byte enables:
  - write 0xAABBCCDD to address 5 with `wr_be` = 4'b1111;
  - then write 0x11223344 to address 5 with `wr_be` = 4'b0101;
  - read address 5 → 0xAA22CC44.
- Collision: address 3 holds 0x0; write 0xDEADBEEF with `wr_be` = 4'b1111 and read address 3 in the same cycle → `READ_FIRST` returns 0x00000000 and `WRITE_FIRST` returns 0xDEADBEEF.
- Latency and streaming: with `READ_LATENCY` = 2, issue reads of addresses 0 to 7 on consecutive cycles → `rd_valid` is high for 8 consecutive cycles starting 2 cycles after the first request, with data in order.
- Gating: `wr_en` and `rd_en` asserted while `ready` = 0 → no `rd_valid`, and the target address still reads 0 after `ready`.
- Reset mid-stream:
  - assert `rst` asynchronously with a read in flight → `rd_data` = 0 and `rd_valid` = 0 immediately, and the in-flight read never appears;
  - with `DEPTH` = 128, the clear restarts and `ready` rises 128 cycles after release.
